uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter with an input FIFO, clocked from the UART clock domain. It drives TX_OUT of the system top. It generalises the fixed 8-bit transmit path in four ways:
- configurable data width
- buffered back-to-back frames
- programmable bit period
- optional parity and a selectable stop-bit count, sampled per frame

## Interface
- DATA_WIDTH, 8, payload bits per frame (5..16)
- PRESCALE_WIDTH, 6, width of the bit-period control
- FIFO_DEPTH, 4, entries in the input FIFO (power of two, ≥2)
- UART_CLK  in  1  sole clock, rising-edge
- RST  in  1  synchronous, active-high reset
- TX_DATA  in  DATA_WIDTH  payload to queue
- TX_VALID  in  1  TX_DATA valid this cycle
- TX_READY  out  1  FIFO can accept (not full)
- PRESCALE  in  PRESCALE_WIDTH  UART_CLK cycles per bit; 0 treated as 1
- STOP2  in  1  0 = one stop bit, 1 = two stop bits
- PAR_EN  in  1  parity bit inserted (present only with UART_TX_PARITY_EN)
- PAR_TYP  in  1  0 = even, 1 = odd (present only with UART_TX_PARITY_EN)
- TX_OUT  out  1  serial line, idle high
- BUSY  out  1  frame in progress
- FIFO_COUNT  out  $clog2(FIFO_DEPTH+1)  occupied entries

## Operation
- **Push:** occurs when TX_VALID && TX_READY. TX_READY = (FIFO_COUNT != FIFO_DEPTH). Push while full is ignored; no data is lost from the FIFO.
- **FSM states:** IDLE → START → DATA → [PARITY] → STOP1 → [STOP2] → IDLE or START.
- **IDLE:**
  - TX_OUT=1, BUSY=0.
  - If the FIFO is non-empty: pop the head into the shift register, latch PRESCALE/STOP2/PAR_EN/PAR_TYP, go to START.
- **START:** TX_OUT=0 for one bit period.
- **DATA:** DATA_WIDTH bits, LSB first; a bit counter runs 0..DATA_WIDTH-1.
- **PARITY:** entered only if the latched PAR_EN=1.
  - Bit value = XOR of payload, XOR latched PAR_TYP.
- **STOP1 / STOP2:** TX_OUT=1 for one bit period each. STOP2 is entered only if the latched STOP2=1.
- **End of last stop bit:**
  - FIFO non-empty → pop and go directly to START; no idle gap, new config latched.
  - FIFO empty → IDLE.
- **Config changes mid-frame** have no effect until the next pop.
- **Bit timer:** counts 0..N-1, where N = max(PRESCALE,1). The state/bit advance happens on the cycle the counter equals N-1.
- **Simultaneous push and pop:** FIFO_COUNT is unchanged; both are performed.
- **Reset mid-frame:** the frame is aborted, the FIFO is flushed, and the FSM goes to IDLE. No partial stop bit is emitted.
- **Reset values:** TX_OUT=1, BUSY=0, TX_READY=1, FIFO_COUNT=0.

## Timing
- **Push-to-line latency (FIFO empty, IDLE):**
  - Push at edge k.
  - Pop at edge k+1.
  - TX_OUT falls after edge k+1.
  - BUSY rises at the same edge as TX_OUT falls.
- **Frame length:** (1 + DATA_WIDTH + P + S) × N cycles, with P ∈ {0,1} and S ∈ {1,2}.
- **BUSY** deasserts at the edge that returns the FSM to IDLE.
- **Back-to-back frames** are contiguous. The START of frame n+1 directly follows the last stop cycle of frame n.
- **Outputs:** TX_OUT, BUSY and FIFO_COUNT are registered. TX_READY is decoded from the registered count.

## Configuration
- **Macro:** UART_TX_PARITY_EN.
- **Defined:**
  - PAR_EN/PAR_TYP ports exist.
  - The PARITY state and parity generator are built.
- **Undefined:**
  - Ports are absent.
  - PARITY state and XOR tree are removed.
  - Frames never contain a parity bit; P=0 always.

## Structure
- **Shared package uart_pkg:**
  - State enum (IDLE, START, DATA, PARITY, STOP1, STOP2).
  - Parity type constants PAR_EVEN=0, PAR_ODD=1.
  - Idle line level constant = 1.
- **Sub-module uart_tx_fifo:** synchronous FIFO, parametrised DATA_WIDTH/FIFO_DEPTH, with push, pop, count, full and empty. It is instantiated once.
- **Top level:** the serialiser FSM, bit timer, bit counter and parity logic live in uart_tx_param.

## Test plan
- **Single frame, no parity:** DATA_WIDTH=8, PRESCALE=8, STOP2=0, push 0xA5.
  - TX_OUT low 8 cycles.
  - Then bits 1,0,1,0,0,1,0,1, 8 cycles each.
  - Then high.
  - BUSY high exactly 80 cycles.
- **Parity (macro defined):** PRESCALE=4, push 0xA5.
  - PAR_TYP=0 → parity bit 0.
  - PAR_TYP=1 → parity bit 1.
  - Frame 44 cycles.
- **Back-to-back with two stop bits:** push 0x01, 0x02, 0x03 in consecutive cycles, STOP2=1, PRESCALE=2.
  - Three contiguous 22-cycle frames.
  - FIFO_COUNT peaks at 2.
  - BUSY never drops between frames.
- **Full FIFO:** hold TX_VALID with PRESCALE=63, FIFO_DEPTH=4.
  - Five pushes accepted: one popped into the frame, four queued.
  - TX_READY=0 while FIFO_COUNT=4.
  - A further push is dropped; the sixth value never appears on TX_OUT.
- **Mid-frame reset:** assert RST for 1 cycle during DATA bit 3.
  - Next cycle: TX_OUT=1, BUSY=0, FIFO_COUNT=0, TX_READY=1.
  - A subsequent push of 0x5A transmits cleanly.
- **Config latching and PRESCALE=0:**
  - Change PRESCALE 8→2 mid-frame: the current frame stays at 8 cycles/bit and the next frame uses 2.
  - PRESCALE=0 produces 1 cycle per bit.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states and line/parity constants for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_param_if.sv
// rtl/uart_tx_param_if.sv - payload push handshake between a producer and the UART transmitter
interface uart_tx_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] TX_DATA;
    logic                  TX_VALID;
    logic                  TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous input FIFO with registered occupancy count
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            push_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic                            pop_i,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
    output logic                            full_o,
    output logic                            empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - buffered UART serialiser with per-frame bit period and stop count
// Parity bit and PAR_EN/PAR_TYP ports are built only when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                            UART_CLK,
    input  logic                            RST,
    uart_tx_param_if.slave                  s_if,
    input  logic [PRESCALE_WIDTH-1:0]       PRESCALE,
    input  logic                            STOP2,
`ifdef UART_TX_PARITY_EN
    input  logic                            PAR_EN,
    input  logic                            PAR_TYP,
`endif
    output logic                            TX_OUT,
    output logic                            BUSY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_COUNT
);
    import uart_pkg::*;

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int PW = PRESCALE_WIDTH;

    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [PW-1:0]         timer_q;
    logic [PW-1:0]         n_m1_q;
    logic [PW-1:0]         n_m1_d;
    logic                  stop2_q;
    logic                  tx_out_q;
    logic                  busy_q;
`ifdef UART_TX_PARITY_EN
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  par_bit_d;
`endif

    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  bit_end;
    logic                  last_stop;
    logic                  pop;

    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (UART_CLK),
        .rst_i   (RST),
        .push_i  (s_if.TX_VALID),
        .wdata_i (s_if.TX_DATA),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (FIFO_COUNT),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign s_if.TX_READY = !fifo_full;
    assign TX_OUT        = tx_out_q;
    assign BUSY          = busy_q;

    // The timer holds N-1 so a zero prescale degenerates to one cycle per bit.
    assign n_m1_d    = (PRESCALE == '0) ? '0 : PRESCALE - PW'(1);
    assign bit_end   = (timer_q == n_m1_q);
    assign last_stop = bit_end && (((state_q == STOP1) && !stop2_q) || (state_q == uart_pkg::STOP2));
    assign pop       = !fifo_empty && ((state_q == IDLE) || last_stop);
`ifdef UART_TX_PARITY_EN
    assign par_bit_d = (^fifo_rdata) ^ (PAR_TYP == PAR_ODD);
`endif

    always_ff @(posedge UART_CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            n_m1_q    <= '0;
            stop2_q   <= 1'b0;
            tx_out_q  <= LINE_IDLE;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else if (pop) begin
            shreg_q   <= fifo_rdata;
            n_m1_q    <= n_m1_d;
            stop2_q   <= STOP2;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= PAR_EN;
            par_bit_q <= par_bit_d;
`endif
            timer_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= START;
            tx_out_q  <= 1'b0;
            busy_q    <= 1'b1;
        end else if (state_q == IDLE) begin
            timer_q  <= '0;
            tx_out_q <= LINE_IDLE;
            busy_q   <= 1'b0;
        end else if (!bit_end) begin
            timer_q <= timer_q + PW'(1);
        end else begin
            timer_q <= '0;
            case (state_q)
                START: begin
                    tx_out_q  <= shreg_q[0];
                    shreg_q   <= shreg_q >> 1;
                    bit_cnt_q <= '0;
                    state_q   <= DATA;
                end
                DATA: begin
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            tx_out_q <= par_bit_q;
                            state_q  <= PARITY;
                        end else begin
                            tx_out_q <= LINE_IDLE;
                            state_q  <= STOP1;
                        end
`else
                        tx_out_q <= LINE_IDLE;
                        state_q  <= STOP1;
`endif
                    end else begin
                        tx_out_q  <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_out_q <= LINE_IDLE;
                    state_q  <= STOP1;
                end
`endif
                STOP1: begin
                    tx_out_q <= LINE_IDLE;
                    if (stop2_q) begin
                        state_q <= uart_pkg::STOP2;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    tx_out_q <= LINE_IDLE;
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - scoreboard bench: expected frames queued at push, line waveform checked by a monitor
module tb_uart_tx_param;
    localparam int DW = 8;
    localparam int PW = 6;
    localparam int FD = 4;
    localparam int CW = $clog2(FD + 1);

    typedef struct {
        logic [DW-1:0] d;
        int            n;
        bit            s2;
        bit            pe;
        bit            pt;
    } frame_t;

    logic          UART_CLK = 1'b0;
    logic          RST      = 1'b1;
    logic [PW-1:0] PRESCALE = PW'(8);
    logic          STOP2    = 1'b0;
`ifdef UART_TX_PARITY_EN
    logic          PAR_EN   = 1'b0;
    logic          PAR_TYP  = 1'b0;
`endif
    logic          TX_OUT;
    logic          BUSY;
    logic [CW-1:0] FIFO_COUNT;

    uart_tx_param_if #(.DATA_WIDTH(DW)) tx_if ();

    uart_tx_param #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW),
        .FIFO_DEPTH     (FD)
    ) dut (
        .UART_CLK   (UART_CLK),
        .RST        (RST),
        .s_if       (tx_if),
        .PRESCALE   (PRESCALE),
        .STOP2      (STOP2),
`ifdef UART_TX_PARITY_EN
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
`endif
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY),
        .FIFO_COUNT (FIFO_COUNT)
    );

    always #5 UART_CLK = ~UART_CLK;

    int     checks = 0;
    int     errors = 0;
    frame_t exp_q[$];
    bit     in_frame = 1'b0;

    // Line level of a frame at cycle c: bit index is c / N over start, data, parity, stops.
    function automatic logic exp_level(input frame_t f, input int c);
        int            b;
        logic [DW-1:0] sh;
        b = c / f.n;
        if (b == 0) return 1'b0;
        if (b <= DW) begin
            sh = f.d >> (b - 1);
            return sh[0];
        end
        if (f.pe && b == DW + 1) return (^f.d) ^ f.pt;
        return 1'b1;
    endfunction

    function automatic int frame_len(input frame_t f);
        return (1 + DW + int'(f.pe) + (f.s2 ? 2 : 1)) * f.n;
    endfunction

    function automatic int eff_n(input logic [PW-1:0] p);
        return (p == '0) ? 1 : int'(p);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    initial begin : monitor
        frame_t cur;
        int     cyc, len, bad_tx, bad_busy;
        logic   prev_tx;
        prev_tx = 1'b1;
        cyc = 0; len = 0; bad_tx = 0; bad_busy = 0;
        forever begin
            @(negedge UART_CLK);
            #1;
            if (RST) begin
                in_frame = 1'b0;
                exp_q.delete();
            end else if (in_frame) begin
                if (TX_OUT !== exp_level(cur, cyc)) bad_tx++;
                if (BUSY !== 1'b1) bad_busy++;
                cyc++;
                if (cyc == len) begin
                    in_frame = 1'b0;
                    checks += 2;
                    if (bad_tx != 0) begin
                        errors++;
                        $display("FAIL frame_tx data=%h n=%0d bad_cycles=%0d required 0", cur.d, cur.n, bad_tx);
                    end
                    if (bad_busy != 0) begin
                        errors++;
                        $display("FAIL frame_busy data=%h low_cycles=%0d required 0", cur.d, bad_busy);
                    end
                end
            end else if (TX_OUT === 1'b0 && prev_tx === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual start bit required idle line");
                end else begin
                    cur      = exp_q.pop_front();
                    len      = frame_len(cur);
                    cyc      = 1;
                    bad_tx   = 0;
                    bad_busy = (BUSY !== 1'b1) ? 1 : 0;
                    in_frame = 1'b1;
                end
            end else if (TX_OUT === 1'b1) begin
                checks++;
                if (BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_busy actual %b required 0", BUSY);
                end
            end
            prev_tx = TX_OUT;
        end
    end

    task automatic push_word(input logic [DW-1:0] d, input int n, output bit acc);
        frame_t f;
        @(negedge UART_CLK);
        tx_if.TX_DATA  = d;
        tx_if.TX_VALID = 1'b1;
        acc = tx_if.TX_READY;
        if (acc) begin
            f.d  = d;
            f.n  = n;
            f.s2 = STOP2;
`ifdef UART_TX_PARITY_EN
            f.pe = PAR_EN;
            f.pt = PAR_TYP;
`else
            f.pe = 1'b0;
            f.pt = 1'b0;
`endif
            exp_q.push_back(f);
        end
    endtask

    task automatic end_push();
        @(negedge UART_CLK);
        tx_if.TX_VALID = 1'b0;
    endtask

    task automatic push_one(input logic [DW-1:0] d, input int n);
        bit acc;
        push_word(d, n, acc);
        end_push();
        check("push_accepted", int'(acc), 1);
    endtask

    task automatic measure_busy(input int budget, output int run);
        int w;
        w = 0;
        run = 0;
        while (BUSY !== 1'b1 && w < budget) begin
            @(negedge UART_CLK);
            w++;
        end
        while (BUSY === 1'b1 && run < 5000) begin
            run++;
            @(negedge UART_CLK);
        end
    endtask

    task automatic wait_drain(input int budget);
        int w;
        w = 0;
        while (w < budget && !(exp_q.size() == 0 && BUSY === 1'b0 && FIFO_COUNT == '0 && !in_frame)) begin
            @(negedge UART_CLK);
            w++;
        end
        check("drain_pending_frames", exp_q.size() + int'(in_frame) + int'(BUSY === 1'b1), 0);
        repeat (3) @(negedge UART_CLK);
    endtask

    initial begin : stimulus
        int  run, peak, acc_cnt, w, k;
        bit  acc;
        tx_if.TX_VALID = 1'b0;
        tx_if.TX_DATA  = '0;

        repeat (3) @(negedge UART_CLK);
        check("reset_tx_out", int'(TX_OUT), 1);
        check("reset_busy", int'(BUSY), 0);
        check("reset_tx_ready", int'(tx_if.TX_READY), 1);
        check("reset_fifo_count", int'(FIFO_COUNT), 0);
        RST = 1'b0;
        repeat (2) @(negedge UART_CLK);

        PRESCALE = PW'(8);
        STOP2    = 1'b0;
        fork
            measure_busy(20, run);
            push_one(8'hA5, 8);
        join
        check("single_busy_cycles", run, 80);
        wait_drain(200);

`ifdef UART_TX_PARITY_EN
        PRESCALE = PW'(4);
        PAR_EN   = 1'b1;
        for (int t = 0; t < 2; t++) begin
            PAR_TYP = t[0];
            fork
                measure_busy(20, run);
                push_one(8'hA5, 4);
            join
            check("parity_busy_cycles", run, 44);
            wait_drain(200);
        end
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
`endif

        PRESCALE = PW'(2);
        STOP2    = 1'b1;
        peak     = 0;
        fork
            measure_busy(20, run);
            begin
                for (int i = 1; i <= 3; i++) begin
                    push_word(DW'(i), 2, acc);
                    check("b2b_accepted", int'(acc), 1);
                end
                end_push();
            end
            repeat (80) begin
                @(negedge UART_CLK);
                if (int'(FIFO_COUNT) > peak) peak = int'(FIFO_COUNT);
            end
        join
        check("b2b_busy_cycles", run, 66);
        check("b2b_count_peak", peak, 2);
        wait_drain(200);
        STOP2 = 1'b0;

        PRESCALE = PW'(63);
        acc_cnt  = 0;
        peak     = 0;
        for (int i = 0; i < 8; i++) begin
            push_word(DW'(8'h10 + i), 63, acc);
            acc_cnt += int'(acc);
            if (int'(FIFO_COUNT) > peak) peak = int'(FIFO_COUNT);
            if (FIFO_COUNT == CW'(FD)) check("full_tx_ready", int'(tx_if.TX_READY), 0);
        end
        end_push();
        check("full_accepted", acc_cnt, 5);
        check("full_count_peak", peak, 4);
        wait_drain(4000);

        PRESCALE = PW'(8);
        push_one(DW'($urandom), 8);
        w = 0;
        while (BUSY !== 1'b1 && w < 20) begin
            @(negedge UART_CLK);
            w++;
        end
        check("reset_frame_started", int'(BUSY), 1);
        repeat (35) @(negedge UART_CLK);
        RST = 1'b1;
        @(negedge UART_CLK);
        RST = 1'b0;
        check("midreset_tx_out", int'(TX_OUT), 1);
        check("midreset_busy", int'(BUSY), 0);
        check("midreset_fifo_count", int'(FIFO_COUNT), 0);
        check("midreset_tx_ready", int'(tx_if.TX_READY), 1);
        push_one(8'h5A, 8);
        wait_drain(300);

        PRESCALE = PW'(8);
        push_word(DW'($urandom), 8, acc);
        check("latch_first_accepted", int'(acc), 1);
        push_word(DW'($urandom), 2, acc);
        check("latch_second_accepted", int'(acc), 1);
        end_push();
        repeat (20) @(negedge UART_CLK);
        PRESCALE = PW'(2);
        wait_drain(300);

        PRESCALE = PW'(0);
        fork
            measure_busy(20, run);
            push_one(DW'($urandom), 1);
        join
        check("prescale0_busy_cycles", run, 10);
        wait_drain(100);

        for (int b = 0; b < 6; b++) begin
            PRESCALE = PW'($urandom_range(0, 5));
            STOP2    = 1'($urandom_range(0, 1));
`ifdef UART_TX_PARITY_EN
            PAR_EN   = 1'($urandom_range(0, 1));
            PAR_TYP  = 1'($urandom_range(0, 1));
`endif
            k = int'($urandom_range(1, 4));
            for (int i = 0; i < k; i++) begin
                push_word(DW'($urandom), eff_n(PRESCALE), acc);
                check("rand_accepted", int'(acc), 1);
                end_push();
                repeat ($urandom_range(0, 3)) @(negedge UART_CLK);
            end
            wait_drain(1000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
